// File: rtl/core_pkg.sv
// Core-wide width constants and control micro-op encodings shared by the pipeline stages.
package core_pkg;

    localparam int CORE_ADDR_W     = 32;
    localparam int CORE_DATA_W     = 32;
    localparam int CORE_RF_ADDR_W  = 5;
    localparam int CORE_CSR_ADDR_W = 12;
    localparam int CORE_PC_CTRL_W  = 3;
    localparam int CORE_CSR_CTRL_W = 2;

    typedef enum logic [CORE_CSR_CTRL_W-1:0] {
        CSR_CTRL_NONE  = 2'd0,
        CSR_CTRL_WRITE = 2'd1,
        CSR_CTRL_SET   = 2'd2,
        CSR_CTRL_CLEAR = 2'd3
    } csr_ctrl_e;

endpackage

// File: rtl/exe2ctrl_pkg.sv
// EXE->CTRL record layout shared by the queue, its hazard CAM and the consumers.
package exe2ctrl_pkg;

    import core_pkg::*;

    typedef struct packed {
        logic [CORE_ADDR_W-1:0]     pc;
        logic [CORE_RF_ADDR_W-1:0]  rd;
        logic [CORE_CSR_ADDR_W-1:0] csr_waddr;
        logic [CORE_DATA_W-1:0]     exe_out;
        logic [CORE_DATA_W-1:0]     op3;
        logic [CORE_PC_CTRL_W-1:0]  pc_ctrl;
        csr_ctrl_e                  csr_ctrl;
    } exe2ctrl_t;

    localparam int EXE2CTRL_W = $bits(exe2ctrl_t);

endpackage

// File: rtl/exe2ctrl_hazard_cam.sv
// Purpose: RAW hazard lookup of GPR/CSR sources against every occupied queue entry.
// Latency: combinational from queue state; the record being offered is not looked at.
// Backpressure: none; flush forces both hits low.
module exe2ctrl_hazard_cam
    import core_pkg::*;
    import exe2ctrl_pkg::*;
#(
    parameter int DEPTH          = 2,
    parameter int RF_ADDR_WIDTH  = CORE_RF_ADDR_W,
    parameter int CSR_ADDR_WIDTH = CORE_CSR_ADDR_W,
    localparam int PTR_W         = $clog2(DEPTH),
    localparam int CNT_W         = PTR_W + 1
) (
    input  exe2ctrl_t                 entry_i [DEPTH],
    input  logic [PTR_W-1:0]          rd_ptr_i,
    input  logic [CNT_W-1:0]          count_i,
    input  logic                      flush_i,
    input  logic [RF_ADDR_WIDTH-1:0]  rs1_i,
    input  logic [RF_ADDR_WIDTH-1:0]  rs2_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i,
    output logic                      gpr_hit_o,
    output logic                      csr_hit_o
);

    logic [DEPTH-1:0] valid_mask;
    logic             gpr_any;
    logic             csr_any;

    always_comb begin
        valid_mask = '0;
        gpr_any    = 1'b0;
        csr_any    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // Distance from the head, wrapping naturally, decides occupancy.
            valid_mask[i] = {1'b0, PTR_W'(PTR_W'(i) - rd_ptr_i)} < count_i;
            if (valid_mask[i] && (entry_i[i].rd != '0) &&
                ((entry_i[i].rd == rs1_i) || (entry_i[i].rd == rs2_i))) begin
                gpr_any = 1'b1;
            end
            if (valid_mask[i] && (entry_i[i].csr_ctrl != CSR_CTRL_NONE) &&
                (entry_i[i].csr_waddr == csr_raddr_i)) begin
                csr_any = 1'b1;
            end
        end
        gpr_hit_o = gpr_any && !flush_i;
        csr_hit_o = csr_any && !flush_i;
    end

endmodule

// File: rtl/exe2ctrl_queue.sv
// Purpose: DEPTH-entry valid/ready FIFO of EXE->CTRL records with flush and RAW lookup.
// Latency: 1 cycle push-to-head; 0 cycles on an empty queue when EXE2CTRL_QUEUE_BYPASS_EN is defined.
// Backpressure: s_ready_o low when full, no pass-through on a simultaneous pop.
module exe2ctrl_queue
    import core_pkg::*;
    import exe2ctrl_pkg::*;
#(
    parameter int DEPTH          = 2,
    parameter int ADDR_WIDTH     = CORE_ADDR_W,
    parameter int DATA_WIDTH     = CORE_DATA_W,
    parameter int RF_ADDR_WIDTH  = CORE_RF_ADDR_W,
    parameter int CSR_ADDR_WIDTH = CORE_CSR_ADDR_W,
    parameter int PC_CTRL_WIDTH  = CORE_PC_CTRL_W,
    parameter int CSR_CTRL_WIDTH = CORE_CSR_CTRL_W
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    input  logic [EXE2CTRL_W-1:0]      s_payload_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [EXE2CTRL_W-1:0]      m_payload_o,
    input  logic                       flush_i,
    input  logic [RF_ADDR_WIDTH-1:0]   rs1_i,
    input  logic [RF_ADDR_WIDTH-1:0]   rs2_i,
    input  logic [CSR_ADDR_WIDTH-1:0]  csr_raddr_i,
    output logic                       gpr_hit_o,
    output logic                       csr_hit_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    // The record layout is fixed by the package; width parameters must agree with it.
    localparam bit WIDTHS_OK = (ADDR_WIDTH == CORE_ADDR_W) && (DATA_WIDTH == CORE_DATA_W) &&
                               (RF_ADDR_WIDTH == CORE_RF_ADDR_W) &&
                               (CSR_ADDR_WIDTH == CORE_CSR_ADDR_W) &&
                               (PC_CTRL_WIDTH == CORE_PC_CTRL_W) &&
                               (CSR_CTRL_WIDTH == CORE_CSR_CTRL_W) && (DEPTH >= 2) &&
                               ((DEPTH & (DEPTH - 1)) == 0);

    exe2ctrl_t        entry_q [DEPTH];
    exe2ctrl_t        entry_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    exe2ctrl_t        s_rec;
    exe2ctrl_t        head;
    logic             empty;
    logic             bypass_take;
    logic             push;
    logic             pop;

    assign s_rec   = exe2ctrl_t'(s_payload_i);
    assign count_o = count_q;

    always_comb begin
        empty     = (count_q == '0);
        s_ready_o = rstn_i && (count_q != FULL_CNT);
`ifdef EXE2CTRL_QUEUE_BYPASS_EN
        m_valid_o   = rstn_i && !flush_i && (empty ? s_valid_i : 1'b1);
        head        = empty ? s_rec : entry_q[rd_ptr_q];
        bypass_take = empty && m_valid_o && m_ready_i;
`else
        m_valid_o   = !empty && !flush_i;
        head        = entry_q[rd_ptr_q];
        bypass_take = 1'b0;
`endif
        m_payload_o = m_valid_o ? head : '0;
        push        = s_valid_i && s_ready_o && !flush_i && !bypass_take;
        pop         = m_valid_o && m_ready_i && !empty;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) count_d = count_q + CNT_W'(1);
            if (pop && !push) count_d = count_q - CNT_W'(1);
        end

        entry_d = entry_q;
        if (push) entry_d[wr_ptr_q] = s_rec;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        entry_q <= entry_d;
    end

    exe2ctrl_hazard_cam #(
        .DEPTH          (DEPTH),
        .RF_ADDR_WIDTH  (RF_ADDR_WIDTH),
        .CSR_ADDR_WIDTH (CSR_ADDR_WIDTH)
    ) u_hazard_cam (
        .entry_i     (entry_q),
        .rd_ptr_i    (rd_ptr_q),
        .count_i     (count_q),
        .flush_i     (flush_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .csr_raddr_i (csr_raddr_i),
        .gpr_hit_o   (gpr_hit_o),
        .csr_hit_o   (csr_hit_o)
    );

    a_widths: assert property (@(posedge clk_i) WIDTHS_OK);
    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
        push |-> (count_q != FULL_CNT));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rstn_i)
        pop |-> (count_q != '0));

endmodule

// File: tb/tb_exe2ctrl_queue.sv
// Directed bench for exe2ctrl_queue (DEPTH=2): ordering, full/wrap, hazards, flush, async reset, bypass.
module tb_exe2ctrl_queue;
    import core_pkg::*;
    import exe2ctrl_pkg::*;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  s_valid;
    logic                  s_ready;
    logic [EXE2CTRL_W-1:0] s_pay;
    logic                  m_valid;
    logic                  m_ready;
    logic [EXE2CTRL_W-1:0] m_pay;
    logic                  flush;
    logic [4:0]            rs1, rs2;
    logic [11:0]           csr_raddr;
    logic                  gpr_hit, csr_hit;
    logic [1:0]            count;

    int n_chk  = 0;
    int n_pass = 0;

    exe2ctrl_queue #(.DEPTH(2)) dut (
        .clk_i(clk), .rstn_i(rstn), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_payload_i(s_pay), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .m_payload_o(m_pay), .flush_i(flush), .rs1_i(rs1), .rs2_i(rs2),
        .csr_raddr_i(csr_raddr), .gpr_hit_o(gpr_hit), .csr_hit_o(csr_hit),
        .count_o(count)
    );

    always #5 clk = ~clk;

    function automatic exe2ctrl_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic [11:0] ca, input csr_ctrl_e cc);
        exe2ctrl_t r;
        r.pc        = pc;
        r.rd        = rd;
        r.csr_waddr = ca;
        r.exe_out   = pc ^ 32'hA5A5_0000;
        r.op3       = ~pc;
        r.pc_ctrl   = rd[2:0];
        r.csr_ctrl  = cc;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; flush = 1'b0; m_ready = 1'b1; s_valid = 1'b1;
        s_pay = mk(32'h10, 5'd1, 12'h300, CSR_CTRL_WRITE);
        rs1 = 5'd1; rs2 = 5'd1; csr_raddr = 12'h300;
        #2;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %b exp 0", m_valid); else n_pass++;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready got %b exp 0", s_ready); else n_pass++;
        n_chk++; if (count !== 2'd0) $display("FAIL rst_count got %0d exp 0", count); else n_pass++;
        n_chk++; if (gpr_hit !== 1'b0) $display("FAIL rst_gpr_hit got %b exp 0", gpr_hit); else n_pass++;
        n_chk++; if (csr_hit !== 1'b0) $display("FAIL rst_csr_hit got %b exp 0", csr_hit); else n_pass++;
        n_chk++; if (m_pay !== '0) $display("FAIL rst_payload got %h exp 0", m_pay); else n_pass++;
        s_valid = 1'b0; m_ready = 1'b0; rs1 = '0; rs2 = '0; csr_raddr = '0;
        tick; tick;
        rstn = 1'b1;
        #1;
        n_chk++; if (s_ready !== 1'b1) $display("FAIL rel_s_ready got %b exp 1", s_ready); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL rel_m_valid got %b exp 0", m_valid); else n_pass++;
        tick;
    endtask

    task automatic test_order;
        exe2ctrl_t a, b;
        a = mk(32'h100, 5'd5, 12'h000, CSR_CTRL_NONE);
        b = mk(32'h104, 5'd6, 12'h000, CSR_CTRL_NONE);
        s_valid = 1'b1; s_pay = a;
        tick;
        n_chk++; if (count !== 2'd1) $display("FAIL ord_cnt1 got %0d exp 1", count); else n_pass++;
        n_chk++; if (m_valid !== 1'b1) $display("FAIL ord_valid got %b exp 1", m_valid); else n_pass++;
        n_chk++; if (m_pay !== a) $display("FAIL ord_head_a got %h exp %h", m_pay, a); else n_pass++;
        s_pay = b;
        tick;
        n_chk++; if (count !== 2'd2) $display("FAIL ord_cnt2 got %0d exp 2", count); else n_pass++;
        n_chk++; if (m_pay !== a) $display("FAIL ord_head_a2 got %h exp %h", m_pay, a); else n_pass++;
        s_valid = 1'b0; m_ready = 1'b1;
        tick;
        n_chk++; if (count !== 2'd1) $display("FAIL ord_cnt3 got %0d exp 1", count); else n_pass++;
        n_chk++; if (m_pay !== b) $display("FAIL ord_head_b got %h exp %h", m_pay, b); else n_pass++;
        tick;
        n_chk++; if (count !== 2'd0) $display("FAIL ord_cnt4 got %0d exp 0", count); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL ord_empty got %b exp 0", m_valid); else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_full_wrap;
        exe2ctrl_t c, d, e;
        c = mk(32'h200, 5'd1, 12'h000, CSR_CTRL_NONE);
        d = mk(32'h204, 5'd2, 12'h000, CSR_CTRL_NONE);
        e = mk(32'h208, 5'd3, 12'h000, CSR_CTRL_NONE);
        s_valid = 1'b1; s_pay = c; tick;
        s_pay = d; tick;
        s_pay = e; #1;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", s_ready); else n_pass++;
        tick;
        n_chk++; if (count !== 2'd2) $display("FAIL full_hold_cnt got %0d exp 2", count); else n_pass++;
        m_ready = 1'b1; #1;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL full_nopass got %b exp 0", s_ready); else n_pass++;
        tick;
        n_chk++; if (count !== 2'd1) $display("FAIL full_pop_cnt got %0d exp 1", count); else n_pass++;
        n_chk++; if (m_pay !== d) $display("FAIL full_head_d got %h exp %h", m_pay, d); else n_pass++;
        m_ready = 1'b0;
        tick;
        n_chk++; if (count !== 2'd2) $display("FAIL wrap_cnt got %0d exp 2", count); else n_pass++;
        s_valid = 1'b0; m_ready = 1'b1;
        tick;
        n_chk++; if (m_pay !== e) $display("FAIL wrap_head_e got %h exp %h", m_pay, e); else n_pass++;
        tick;
        n_chk++; if (count !== 2'd0) $display("FAIL wrap_drain got %0d exp 0", count); else n_pass++;
        m_ready = 1'b0;
    endtask

    task automatic test_gpr;
        s_valid = 1'b1; s_pay = mk(32'h300, 5'd7, 12'h000, CSR_CTRL_NONE); tick;
        s_pay = mk(32'h304, 5'd0, 12'h000, CSR_CTRL_NONE); tick;
        s_valid = 1'b0;
        rs1 = 5'd7; rs2 = 5'd3; #1;
        n_chk++; if (gpr_hit !== 1'b1) $display("FAIL gpr_rs1 got %b exp 1", gpr_hit); else n_pass++;
        rs1 = 5'd0; rs2 = 5'd0; #1;
        n_chk++; if (gpr_hit !== 1'b0) $display("FAIL gpr_x0 got %b exp 0", gpr_hit); else n_pass++;
        rs1 = 5'd3; rs2 = 5'd7; #1;
        n_chk++; if (gpr_hit !== 1'b1) $display("FAIL gpr_rs2 got %b exp 1", gpr_hit); else n_pass++;
        rs1 = 5'd7; rs2 = 5'd0; m_ready = 1'b1; #1;
        n_chk++; if (gpr_hit !== 1'b1) $display("FAIL gpr_popping got %b exp 1", gpr_hit); else n_pass++;
        tick;
        m_ready = 1'b0; #1;
        n_chk++; if (gpr_hit !== 1'b0) $display("FAIL gpr_after_pop got %b exp 0", gpr_hit); else n_pass++;
        m_ready = 1'b1; tick; m_ready = 1'b0;
        rs1 = '0; rs2 = '0;
    endtask

    task automatic test_csr;
        csr_raddr = 12'h300;
        s_valid = 1'b1; s_pay = mk(32'h400, 5'd0, 12'h300, CSR_CTRL_WRITE); #1;
        n_chk++; if (csr_hit !== 1'b0) $display("FAIL csr_incoming got %b exp 0", csr_hit); else n_pass++;
        tick;
        s_valid = 1'b0; #1;
        n_chk++; if (csr_hit !== 1'b1) $display("FAIL csr_hit got %b exp 1", csr_hit); else n_pass++;
        csr_raddr = 12'h301; #1;
        n_chk++; if (csr_hit !== 1'b0) $display("FAIL csr_addr_miss got %b exp 0", csr_hit); else n_pass++;
        m_ready = 1'b1; tick; m_ready = 1'b0;
        csr_raddr = 12'h300;
        s_valid = 1'b1; s_pay = mk(32'h404, 5'd0, 12'h300, CSR_CTRL_NONE); tick;
        s_valid = 1'b0; #1;
        n_chk++; if (csr_hit !== 1'b0) $display("FAIL csr_none got %b exp 0", csr_hit); else n_pass++;
        m_ready = 1'b1; tick; m_ready = 1'b0;
        csr_raddr = '0;
    endtask

    task automatic test_flush;
        exe2ctrl_t k;
        k = mk(32'h50c, 5'd12, 12'h000, CSR_CTRL_NONE);
        s_valid = 1'b1; s_pay = mk(32'h500, 5'd9, 12'h340, CSR_CTRL_SET); tick;
        s_pay = mk(32'h504, 5'd10, 12'h000, CSR_CTRL_NONE); tick;
        rs1 = 5'd9; csr_raddr = 12'h340;
        s_pay = mk(32'h508, 5'd11, 12'h000, CSR_CTRL_NONE);
        flush = 1'b1; m_ready = 1'b1; #1;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL fl_m_valid got %b exp 0", m_valid); else n_pass++;
        n_chk++; if (gpr_hit !== 1'b0) $display("FAIL fl_gpr got %b exp 0", gpr_hit); else n_pass++;
        n_chk++; if (csr_hit !== 1'b0) $display("FAIL fl_csr got %b exp 0", csr_hit); else n_pass++;
        tick;
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; #1;
        n_chk++; if (count !== 2'd0) $display("FAIL fl_count got %0d exp 0", count); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL fl_empty got %b exp 0", m_valid); else n_pass++;
        n_chk++; if (gpr_hit !== 1'b0) $display("FAIL fl_gpr_after got %b exp 0", gpr_hit); else n_pass++;
        s_valid = 1'b1; s_pay = k; tick; s_valid = 1'b0;
        n_chk++; if (m_pay !== k) $display("FAIL fl_refill got %h exp %h", m_pay, k); else n_pass++;
        m_ready = 1'b1; tick; m_ready = 1'b0;
        rs1 = '0; csr_raddr = '0;
    endtask

    task automatic test_async_reset;
        s_valid = 1'b1; s_pay = mk(32'h600, 5'd4, 12'h000, CSR_CTRL_NONE); tick;
        s_valid = 1'b0;
        n_chk++; if (count !== 2'd1) $display("FAIL ar_pre_count got %0d exp 1", count); else n_pass++;
        #3 rstn = 1'b0;
        #1;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL ar_m_valid got %b exp 0", m_valid); else n_pass++;
        n_chk++; if (count !== 2'd0) $display("FAIL ar_count got %0d exp 0", count); else n_pass++;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL ar_s_ready got %b exp 0", s_ready); else n_pass++;
        n_chk++; if (m_pay !== '0) $display("FAIL ar_payload got %h exp 0", m_pay); else n_pass++;
        #2 rstn = 1'b1;
        tick;
        n_chk++; if (s_ready !== 1'b1) $display("FAIL ar_rel_ready got %b exp 1", s_ready); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL ar_rel_valid got %b exp 0", m_valid); else n_pass++;
    endtask

    task automatic test_bypass;
        exe2ctrl_t p;
        p = mk(32'h700, 5'd13, 12'h000, CSR_CTRL_NONE);
        s_valid = 1'b1; s_pay = p; m_ready = 1'b1; #1;
`ifdef EXE2CTRL_QUEUE_BYPASS_EN
        n_chk++; if (m_valid !== 1'b1) $display("FAIL byp_valid got %b exp 1", m_valid); else n_pass++;
        n_chk++; if (m_pay !== p) $display("FAIL byp_payload got %h exp %h", m_pay, p); else n_pass++;
        tick;
        s_valid = 1'b0; m_ready = 1'b0; #1;
        n_chk++; if (count !== 2'd0) $display("FAIL byp_count got %0d exp 0", count); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL byp_after got %b exp 0", m_valid); else n_pass++;
`else
        n_chk++; if (m_valid !== 1'b0) $display("FAIL nobyp_valid got %b exp 0", m_valid); else n_pass++;
        tick;
        s_valid = 1'b0; m_ready = 1'b0; #1;
        n_chk++; if (count !== 2'd1) $display("FAIL nobyp_count got %0d exp 1", count); else n_pass++;
        n_chk++; if (m_pay !== p) $display("FAIL nobyp_payload got %h exp %h", m_pay, p); else n_pass++;
        m_ready = 1'b1; tick; m_ready = 1'b0;
        n_chk++; if (count !== 2'd0) $display("FAIL nobyp_drain got %0d exp 0", count); else n_pass++;
`endif
    endtask

    initial begin
        test_reset;
        test_order;
        test_full_wrap;
        test_gpr;
        test_csr;
        test_flush;
        test_async_reset;
        test_bypass;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
